// File: rtl/serial_pattern_gen.sv
// Multi-lane framed serial test-pattern generator: counter, PRBS-7, fixed and walking-one patterns.
// Latency: first frame bit appears on odata at the same clock edge that samples en=1 (1 cycle).
// Backpressure: none; free-running source. en only gates frame starts, and a frame in flight always completes.
//
// Ports:
//   sclk         clock, all logic on the rising edge
//   rst          synchronous active-high reset, overrides everything including a frame in flight
//   en           run enable, sampled in IDLE, at the end of the gap, or at frame end when GAP=0
//   mode         0 counter, 1 PRBS-7, 2 fixed load_val, 3 walking-one; latched at frame start
//   load_val     word sent by every lane in fixed mode; latched at frame start
//   odata        serial data, bit c = lane c, MSB first, zero outside a frame
//   ovalid       high on every cycle carrying a frame bit
//   frame_start  pulse on the first bit of a frame
//   frame_done   pulse on the last bit of a frame
module serial_pattern_gen #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int FRAME_WORDS = 4,
  parameter int GAP         = 2
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [WIDTH-1:0]    load_val,
  output logic [CHANNELS-1:0] odata,
  output logic                ovalid,
  output logic                frame_start,
  output logic                frame_done
);

  // Elaboration-time guards on the supported parameter ranges.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_pattern_gen: WIDTH must be 2..32");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("serial_pattern_gen: CHANNELS must be 1..8");
  end
  if (FRAME_WORDS < 1) begin : g_bad_words
    $error("serial_pattern_gen: FRAME_WORDS must be >= 1");
  end
  if (GAP < 0) begin : g_bad_gap
    $error("serial_pattern_gen: GAP must be >= 0");
  end

  localparam int BW = $clog2(WIDTH);
  localparam int KW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] M_COUNT = 2'd0;
  localparam logic [1:0] M_PRBS  = 2'd1;
  localparam logic [1:0] M_FIXED = 2'd2;
  localparam logic [1:0] M_WALK  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] seq;
  logic [BW-1:0]    bit_cnt;
  logic [KW-1:0]    word_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] shreg [CHANNELS];
  logic [6:0]       lfsr  [CHANNELS];

  logic             last_bit;
  logic             last_word;
  logic             frame_end;
  logic             gap_end;
  logic             start;
  logic             emit;
  logic             word_load;
  logic [1:0]       cur_mode;
  logic [WIDTH-1:0] cur_fixed;
  logic [WIDTH-1:0] seq_next;
  logic [WIDTH-1:0] cur_base;
  int               cur_k;
  logic [BW-1:0]    nxt_bit;
  logic [KW-1:0]    nxt_word;
  logic             nxt_done;
  logic [WIDTH-1:0] ld_word [CHANNELS];

  // Parallel word for lane c, word index k of a frame. PRBS is produced bit by
  // bit from the lane LFSR, so it has no word form here.
  function automatic logic [WIDTH-1:0] pattern_word(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] fixed,
    input logic [WIDTH-1:0] base,
    input int               k,
    input int               c
  );
    logic [WIDTH-1:0] w;
    w = '0;
    case (m)
      M_COUNT: w = base + WIDTH'(k) + WIDTH'(c);
      M_FIXED: w = fixed;
      M_WALK:  w = WIDTH'(1) << ((k + c) % WIDTH);
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    last_bit  = (bit_cnt == BW'(WIDTH - 1));
    last_word = (word_cnt == KW'(FRAME_WORDS - 1));
    frame_end = (state == ST_SHIFT) && last_bit && last_word;
    gap_end   = (GAP > 0) && (state == ST_GAP) &&
                (gap_cnt == GW'((GAP > 0) ? GAP - 1 : 0));
    // With no gap, en is evaluated on the last bit so frames run back to back.
    start     = en && ((state == ST_IDLE) || gap_end || ((GAP == 0) && frame_end));
    emit      = start || ((state == ST_SHIFT) && !frame_end);
    word_load = start || ((state == ST_SHIFT) && last_bit);

    // The frame-start edge uses the live inputs; they are latched at the same edge.
    cur_mode  = start ? mode : mode_q;
    cur_fixed = start ? load_val : load_q;
    seq_next  = seq + WIDTH'(FRAME_WORDS);
    // Back-to-back start: seq has not been written yet, so use its next value.
    cur_base  = (start && frame_end) ? seq_next : seq;
    cur_k     = start ? 0 : int'(word_cnt) + 1;

    nxt_bit   = (start || last_bit) ? '0 : bit_cnt + BW'(1);
    if (start) begin
      nxt_word = '0;
    end else if (last_bit) begin
      nxt_word = word_cnt + KW'(1);
    end else begin
      nxt_word = word_cnt;
    end
    nxt_done  = (nxt_bit == BW'(WIDTH - 1)) && (nxt_word == KW'(FRAME_WORDS - 1));

    for (int c = 0; c < CHANNELS; c++) begin
      ld_word[c] = pattern_word(cur_mode, cur_fixed, cur_base, cur_k, c);
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_q      <= M_COUNT;
      load_q      <= '0;
      seq         <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      odata       <= '0;
      ovalid      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        shreg[c] <= '0;
        lfsr[c]  <= 7'(c + 1);
      end
    end else begin
      // Frame-level control.
      if (start) begin
        mode_q <= mode;
        load_q <= load_val;
      end
      if (frame_end) begin
        seq     <= seq_next;
        gap_cnt <= '0;
      end else if (state == ST_GAP && !gap_end) begin
        gap_cnt <= gap_cnt + GW'(1);
      end

      if (start) begin
        state <= ST_SHIFT;
      end else if (frame_end) begin
        state <= (GAP > 0) ? ST_GAP : ST_IDLE;
      end else if (gap_end) begin
        state <= ST_IDLE;
      end

      if (emit) begin
        bit_cnt  <= nxt_bit;
        word_cnt <= nxt_word;
      end

      // Registered strobes.
      ovalid      <= emit;
      frame_start <= start;
      frame_done  <= emit && nxt_done;

      // Per-lane serial data.
      for (int c = 0; c < CHANNELS; c++) begin
        if (!emit) begin
          odata[c] <= 1'b0;
        end else if (cur_mode == M_PRBS) begin
          // LFSR steps only when it produces a valid bit, so the sequence
          // continues across gaps and frames without reseeding.
          odata[c] <= lfsr[c][6];
          lfsr[c]  <= {lfsr[c][5:0], lfsr[c][6] ^ lfsr[c][5]};
        end else if (word_load) begin
          odata[c] <= ld_word[c][WIDTH-1];
          shreg[c] <= ld_word[c] << 1;
        end else begin
          odata[c] <= shreg[c][WIDTH-1];
          shreg[c] <= shreg[c] << 1;
        end
      end
    end
  end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Parametrised multi-channel serial test-pattern generator, the successor to the single-bit `odata` pattern source. It emits framed, MSB-first serial words on CHANNELS parallel lanes and supports four selectable pattern modes. Frame-start, frame-done and valid strobes are provided, along with a programmable inter-frame gap. It sits at the front of loopback and bring-up benches as the stimulus source for downstream deserialisers and checkers.

Parameters:
WIDTH, 8, bits per serial word (2..32)
CHANNELS, 2, number of parallel serial lanes (1..8)
FRAME_WORDS, 4, words per frame (>=1)
GAP, 2, idle cycles between frames (>=0)

Ports:
sclk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  run enable; sampled in IDLE and at end of GAP
mode  in  2  pattern select: 0 counter, 1 PRBS-7, 2 fixed, 3 walking-one
load_val  in  WIDTH  fixed-mode word
odata  out  CHANNELS  serial data, bit c = lane c
ovalid  out  1  high on every cycle that carries a frame bit
frame_start  out  1  one-cycle pulse on the first bit of a frame
frame_done  out  1  one-cycle pulse on the last bit of a frame

Behaviour:
- Reset, synchronous active-high: odata=0, ovalid=0, frame_start=0, frame_done=0, state=IDLE, seq=0, bit_cnt=0, word_cnt=0. Each lane LFSR is seeded with 7'd1+c.
- Reset has priority over every other input and takes effect at the edge where rst=1, including mid-frame. There is no partial-frame completion after reset.
- FSM states: IDLE, SHIFT, GAP.
- IDLE to SHIFT: at the edge where en=1.
  - mode and load_val are latched at this edge.
  - Word 0 is loaded and its MSB is driven on odata at the same edge, with ovalid=1 and frame_start=1.
  - Latency from en to the first bit is therefore 1 cycle.
- SHIFT: one bit per cycle, MSB first.
  - bit_cnt runs 0..WIDTH-1; word_cnt runs 0..FRAME_WORDS-1.
  - The next word loads seamlessly, with no bubble between words.
  - A frame is exactly FRAME_WORDS*WIDTH valid cycles.
  - frame_done is high together with the last bit.
- After the last bit:
  - GAP>0: go to GAP for GAP cycles with ovalid=0 and odata=0.
  - GAP=0: evaluate en immediately, giving back-to-back frames with no idle cycle.
- End of GAP: if en=1, start the next frame (behaves like IDLE to SHIFT); otherwise go to IDLE.
- en deasserted mid-frame: the current frame completes in full, then the gap runs, then IDLE. Frames are never aborted except by rst.
- mode and load_val changes mid-frame are ignored until the next frame start.
- Pattern rules, where k is the word index in the frame and c is the lane:
  - mode 0 (counter): lane c word = (seq+k+c) mod 2^WIDTH. seq advances by FRAME_WORDS at each frame end, wraps mod 2^WIDTH, and persists across frames until rst.
  - mode 1 (PRBS-7, x^7+x^6+1, per lane, per bit): output bit = lfsr[6]; next lfsr = {lfsr[5:0], lfsr[6]^lfsr[5]}. The LFSR advances only on ovalid cycles, so state persists across frames and gaps. Period is 127 bits. Word boundaries are irrelevant.
  - mode 2 (fixed): every lane sends the latched load_val for every word.
  - mode 3 (walking-one): lane c word = 1 << ((k+c) mod WIDTH).
- Outside SHIFT: odata=0.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
Default parameters (WIDTH=8, CHANNELS=2, FRAME_WORDS=4, GAP=2) unless stated.
1. rst for 2 cycles, then en=1, mode=0:
   - lane0 words 0x00, 0x01, 0x02, 0x03; lane1 words 0x01..0x04.
   - frame_start on valid cycle 1; frame_done on valid cycle 32.
   - Exactly 2 cycles with ovalid=0 follow.
   - Frame 2 lane0 starts at 0x04.
2. mode=1, en held, 2 frames:
   - lane0 (seed 1) first bits 0,0,0,0,0,0,1,0; lfsr after 7 bits = 7'b0000011.
   - Stream matches a reference LFSR model across the gap with no reseed.
   - The sequence repeats after 127 bits.
3. mode=2, load_val=0xA5, change load_val to 0x3C mid-frame:
   - Both lanes send 10100101 ×4 in the current frame.
   - The next frame sends 0x3C.
4. mode=3, then drop en at bit 10:
   - lane0 words 0x01, 0x02, 0x04, 0x08; lane1 words 0x02, 0x04, 0x08, 0x10.
   - The frame completes all 32 bits, then 2 gap cycles, then IDLE with ovalid=0.
5. Assert rst at bit 17 of a mode-0 frame:
   - At the next edge all outputs are 0 and state is IDLE.
   - On re-enable, lane0 restarts at 0x00.
6. GAP=0, en held, mode=0: frame_done on cycle 32 and frame_start on cycle 33, with ovalid continuously 1.
